// File: rtl/seg7_scan_driver.sv
// Converts a latched binary value to four BCD digits with a sequential double-dabble
// engine and time-multiplexes them onto one seg7 decoder with active-low anodes.
module seg7_scan_driver #(
    parameter int WIDTH       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    input  logic             blank_en,
    output logic             busy,
    output logic             ovf,
    output logic [3:0]       bcd,
    output logic [3:0]       an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int SC_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_bin;
    logic [15:0]         r_scr;
    logic [SC_W-1:0]     r_sh_cnt;
    logic                r_ovf_pend;
    logic                r_busy;
    logic                r_ovf;
    logic [3:0]          r_digit [4];
    logic [15:0]         w_adj;
    logic [16+WIDTH-1:0] w_pair;

    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_idx;
    logic [3:0]          r_an;
    logic [3:0]          r_bcd;
    logic                w_blank;
    logic [3:0]          w_an_nxt;
    logic [3:0]          w_bcd_nxt;

    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            return nib + 4'd3;
        end else begin
            return nib;
        end
    endfunction

    // Conversion state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and the add-3 step applied before each shift
    always_comb begin
        w_state_nxt = r_state;
        w_adj       = {dd_adjust(r_scr[15:12]), dd_adjust(r_scr[11:8]),
                       dd_adjust(r_scr[7:4]),   dd_adjust(r_scr[3:0])};
        w_pair      = {w_adj, r_bin};
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_sh_cnt == SC_W'(WIDTH - 1)) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Conversion datapath; overflow is decided at capture so COMMIT can saturate
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin      <= '0;
            r_scr      <= 16'd0;
            r_sh_cnt   <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_digit[k] <= 4'd0;
            end
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_bin      <= value;
                        r_scr      <= 16'd0;
                        r_sh_cnt   <= '0;
                        r_ovf_pend <= (32'(value) > 32'd9999);
                    end
                end
                ST_SHIFT: begin
                    {r_scr, r_bin} <= w_pair << 1;
                    r_sh_cnt       <= r_sh_cnt + SC_W'(1);
                end
                ST_COMMIT: begin
                    r_ovf <= r_ovf_pend;
                    for (int k = 0; k < 4; k++) begin
                        r_digit[k] <= r_ovf_pend ? 4'd9 : r_scr[4*k +: 4];
                    end
                end
                default: begin
                    r_ovf <= r_ovf;
                end
            endcase
        end
    end

    // Slot blanking: a slot goes dark only if it and every higher digit are zero
    always_comb begin
        w_blank   = 1'b0;
        w_an_nxt  = 4'b1111;
        w_bcd_nxt = 4'd0;
        case (r_idx)
            2'd3:    w_blank = (r_digit[3] == 4'd0);
            2'd2:    w_blank = (r_digit[3] == 4'd0) && (r_digit[2] == 4'd0);
            2'd1:    w_blank = (r_digit[3] == 4'd0) && (r_digit[2] == 4'd0) &&
                               (r_digit[1] == 4'd0);
            default: w_blank = 1'b0;
        endcase
        if (blank_en && w_blank) begin
            w_an_nxt  = 4'b1111;
            w_bcd_nxt = 4'd0;
        end else begin
            w_an_nxt  = ~(4'b0001 << r_idx);
            w_bcd_nxt = r_digit[r_idx];
        end
    end

    // Refresh counter, scan index and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_an  <= 4'b1111;
            r_bcd <= 4'd0;
        end else begin
            if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_an  <= w_an_nxt;
            r_bcd <= w_bcd_nxt;
        end
    end

    assign busy = r_busy;
    assign ovf  = r_ovf;
    assign bcd  = r_bcd;
    assign an   = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed and random checks of conversion, saturation, blanking and scan order,
// using a decimal-arithmetic scoreboard filled at load time.
module tb_seg7_scan_driver;

    localparam int WIDTH = 14;
    localparam int DIV   = 4;

    typedef struct packed {
        logic        ovf;
        logic [15:0] dig;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] value;
    logic             load;
    logic             blank_en;
    logic             busy;
    logic             ovf;
    logic [3:0]       bcd;
    logic [3:0]       an;

    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    seg7_scan_driver #(.WIDTH(WIDTH), .REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .blank_en (blank_en),
        .busy     (busy),
        .ovf      (ovf),
        .bcd      (bcd),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int v);
        int   d;
        exp_t e;
        d     = (v > 9999) ? 9999 : v;
        e.ovf = (v > 9999);
        e.dig = {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
        return e;
    endfunction

    // Called at a negedge; the load is captured on the following posedge.
    task automatic start_load(input int v);
        value = WIDTH'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, "/done"}, busy, 1'b0);
    endtask

    task automatic sweep(input logic [15:0] dig, input string tag);
        logic [3:0] lit;
        logic [3:0] exp_lit;
        logic [3:0] pat;
        logic [3:0] obs [4];
        int         bad;
        lit = 4'b0000;
        bad = 0;
        for (int k = 0; k < 4; k++) obs[k] = 4'hF;
        if (blank_en) begin
            exp_lit[0] = 1'b1;
            exp_lit[1] = (dig[15:4] != 12'd0);
            exp_lit[2] = (dig[15:8] != 8'd0);
            exp_lit[3] = (dig[15:12] != 4'd0);
        end else begin
            exp_lit = 4'b1111;
        end
        @(negedge clk);
        for (int s = 0; s < 4 * DIV; s++) begin
            if (bcd > 4'd9) bad++;
            if ($countones(~an) > 1) bad++;
            if (an == 4'b1111 && bcd != 4'd0) bad++;
            if (busy !== 1'b0) bad++;
            for (int k = 0; k < 4; k++) begin
                pat = ~(4'b0001 << k);
                if (an == pat) begin
                    lit[k] = 1'b1;
                    obs[k] = bcd;
                end
            end
            @(negedge clk);
        end
        check({tag, "/lit"}, lit, exp_lit);
        check({tag, "/bad"}, bad, 0);
        for (int k = 0; k < 4; k++) begin
            if (exp_lit[k]) check($sformatf("%s/dig%0d", tag, k), obs[k], dig[4*k +: 4]);
        end
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        check({tag, "/sb_nonempty"}, (sb_q.size() > 0), 1'b1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "/ovf"}, ovf, e.ovf);
            sweep(e.dig, tag);
        end
    endtask

    task automatic do_conv(input int v, input string tag);
        int cyc;
        start_load(v);
        sb_q.push_back(model(v));
        wait_done(tag, cyc);
        check({tag, "/latency"}, cyc, 15);
        pop_and_check(tag);
    endtask

    task automatic ordered(input logic [15:0] dig, input string tag);
        logic [3:0] prev;
        logic [3:0] pat;
        logic       found;
        found = 1'b0;
        prev  = an;
        for (int c = 0; c < 24 && !found; c++) begin
            @(negedge clk);
            if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = an;
        end
        check({tag, "/align"}, found, 1'b1);
        for (int i = 0; i < 4 * DIV; i++) begin
            pat = ~(4'b0001 << (i / DIV));
            check($sformatf("%s/an%0d", tag, i), an, pat);
            check($sformatf("%s/bcd%0d", tag, i), bcd, dig[4*(i/DIV) +: 4]);
            if (i < 4 * DIV - 1) @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int stray;
        int v;
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        value    = '0;
        load     = 1'b0;
        blank_en = 1'b0;

        repeat (3) @(negedge clk);
        check("rst/busy", busy, 1'b0);
        check("rst/ovf", ovf, 1'b0);
        check("rst/an", an, 4'b1111);
        check("rst/bcd", bcd, 4'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rel/an", an, 4'b1110);
        check("rel/bcd", bcd, 4'd0);

        do_conv(1234, "v1234");
        ordered(16'h1234, "scan1234");

        do_conv(12000, "v12000");
        do_conv(42, "v42");

        blank_en = 1'b1;
        do_conv(7, "blank7");
        do_conv(0, "blank0");
        blank_en = 1'b0;
        sweep(16'h0000, "noblank0");

        start_load(5555);
        sb_q.push_back(model(5555));
        repeat (4) @(negedge clk);
        start_load(1111);
        wait_done("v5555", cyc);
        pop_and_check("v5555");
        check("ignored/sb_empty", sb_q.size(), 0);

        do_conv(9999, "v9999");
        do_conv(10000, "v10000");

        start_load(8888);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort/busy", busy, 1'b0);
        check("abort/an", an, 4'b1111);
        check("abort/bcd", bcd, 4'd0);
        check("abort/ovf", ovf, 1'b0);
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy !== 1'b0) stray++;
        end
        check("abort/no_busy", stray, 0);
        sweep(16'h0000, "abort");

        reset = 1'b1;
        value = WIDTH'(8888);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        reset = 1'b0;
        check("rstload/busy", busy, 1'b0);
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy !== 1'b0) stray++;
        end
        check("rstload/no_busy", stray, 0);
        sweep(16'h0000, "rstload");

        for (int n = 0; n < 500; n++) begin
            v        = int'($urandom_range(16383, 0));
            blank_en = 1'($urandom_range(1, 0));
            do_conv(v, $sformatf("rand%0d_v%0d", n, v));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Upstream feeder for the seg7 decoder. It latches a binary value from the SPI receive path and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto one seg7 instance: one 4-bit BCD nibble plus active-low digit anodes on a 4-digit common-anode display. Optional leading-zero blanking and overflow saturation are included.

Parameters:
WIDTH, 14, width of the binary input (max representable 16383).
REFRESH_DIV, 50000, clk cycles each digit stays lit; must be >= 2.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
value  input  WIDTH  binary value to display
load  input  1  single-cycle strobe; captures value when busy=0
blank_en  input  1  1 = blank leading zero digits
busy  output  1  conversion in progress
ovf  output  1  last accepted value was > 9999 (display saturated)
bcd  output  4  digit nibble, drives seg7 bcd input
an  output  4  active-low anode enables, an[0] = units digit

Behaviour:
- Reset (synchronous, active-high): busy=0, ovf=0, all four digit registers=0, scan index=0, refresh counter=0, bcd=4'd0, an=4'b1111. Reset asserted mid-conversion aborts it; display registers read 0.
- Conversion FSM states:
  - IDLE: on load=1, capture value into shift register, clear scratch BCD, go to SHIFT, busy=1 from the next cycle.
  - SHIFT: runs exactly WIDTH cycles. Each cycle, add 3 to every scratch BCD nibble >= 5, then shift {bcd, bin} left by 1. Go to COMMIT.
  - COMMIT: one cycle. Copy scratch digits to the display registers atomically, set ovf, go to IDLE with busy=0.
  - Latency: load accepted at edge N; display registers and busy=0 valid after edge N+WIDTH+1.
- Overflow: if captured value > 9999, skip the double-dabble result. COMMIT writes 9,9,9,9 and ovf=1; otherwise ovf=0. ovf holds until the next COMMIT or reset.
- Scratch BCD width is 16 bits. Bits beyond thousands are discarded; the overflow path covers that case.
- load while busy=1: ignored, no queueing, no effect on the current conversion.
- load and reset in the same cycle: reset wins.
- Scanner runs independently of the FSM, including during conversion; it shows the old digits until COMMIT.
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances 0→1→2→3→0.
- Outputs bcd and an are registered from the scan index and digit registers, so they update one cycle after an index change.
  - an = one-hot low at position index (index 0 → 4'b1110, 3 → 4'b0111).
  - bcd = digit[index].
- First clock after reset release: an=4'b1110, bcd=digit0=0.
- Blanking: when blank_en=1, digit k (k=3,2,1) is blanked if it and every digit above it are zero. A blanked slot drives an=4'b1111 and bcd=0. Digit 0 is never blanked. blank_en is sampled every cycle with no latching.
- bcd is never outside 0..9, so the seg7 default branch is unreachable.

Test Plan:
- REFRESH_DIV=4, WIDTH=14: reset 3 cycles, then load value=1234 → busy=1 for 15 cycles, busy=0 at edge 16. Scan then shows (an, bcd) = (1110,4), (1101,3), (1011,2), (0111,1), each for 4 cycles, repeating. ovf=0.
- load value=12000 → after 16 cycles the digits read 9,9,9,9 and ovf=1. Then load 42 → ovf=0 and digits read 0,0,4,2.
- blank_en=1, load 7 → slots 1–3 drive an=1111; slot 0 drives an=1110, bcd=7. Load 0 → only an=1110 with bcd=0 lit. blank_en=0 → all four slots lit.
- load 5555, then pulse load with 1111 at cycle +5 → second load ignored; result reads 5555. Boundary values 9999 (ovf=0) and 10000 (ovf=1) are checked.
- Assert reset at cycle +7 of a conversion of 8888 → next cycle busy=0, an=1111, digits 0. No digit 8 appears afterward without a new load.
- Random 500 loads in 0..16383 → each committed digit set equals the decimal value (or 9999 with ovf=1 above 9999). Every displayed bcd is <= 9, and at most one an bit is low at any time.
